// File: rtl/parking_input_frontend.sv
// Parking gate input frontend: synchronised/debounced entrance and exit sensors
// plus a two-digit keypad password assembler with valid/ready handshake.

module parking_input_frontend_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1, sync2;
   logic [CW-1:0] cnt;

   // The flip happens on the edge that would bring cnt to DEBOUNCE_CYCLES,
   // so the stored count never exceeds DEBOUNCE_CYCLES-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module parking_input_frontend #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       raw_entrance,
   input  logic       raw_exit,
   input  logic       key_valid,
   input  logic [1:0] key_digit,
   input  logic       key_clear,
   output logic       key_ready,
   output logic       sensor_entrance,
   output logic       sensor_exit,
   output logic [1:0] password_1,
   output logic [1:0] password_2,
   output logic       pass_done
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0] raw, level;

   assign raw = {raw_exit, raw_entrance};

   for (genvar i = 0; i < 2; i++) begin : g_sensor
      parking_input_frontend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .reset (reset),
         .raw   (raw[i]),
         .level (level[i])
      );
   end

   assign sensor_entrance = level[0];
   assign sensor_exit     = level[1];

   logic [1:0]    state, d1;
   logic [TW-1:0] idle;
   logic          exit_prev;
   logic          accept, exit_rise;

   assign key_ready = (state != FULL);
   assign accept    = key_valid && key_ready;
   assign exit_rise = sensor_exit && !exit_prev;

   // The second digit lives directly in password_2; it is only ever visible in FULL.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= EMPTY;
         d1         <= 2'b00;
         idle       <= '0;
         exit_prev  <= 1'b0;
         password_1 <= 2'b00;
         password_2 <= 2'b00;
         pass_done  <= 1'b0;
      end else begin
         exit_prev <= sensor_exit;
         if (key_clear || (state == FULL && exit_rise)) begin
            state      <= EMPTY;
            d1         <= 2'b00;
            idle       <= '0;
            password_1 <= 2'b00;
            password_2 <= 2'b00;
            pass_done  <= 1'b0;
         end else begin
            case (state)
               EMPTY: begin
                  if (accept) begin
                     d1    <= key_digit;
                     idle  <= '0;
                     state <= ONE;
                  end
               end
               ONE: begin
                  if (accept) begin
                     password_1 <= d1;
                     password_2 <= key_digit;
                     pass_done  <= 1'b1;
                     state      <= FULL;
                  end else if (idle == TW'(TIMEOUT_CYCLES - 1)) begin
                     state <= EMPTY;
                     d1    <= 2'b00;
                     idle  <= '0;
                  end else begin
                     idle <= idle + 1'b1;
                  end
               end
               FULL: ;
               default: state <= EMPTY;
            endcase
         end
      end
   end
endmodule
